// File: rtl/ball_physics_engine.sv
// Single-ball physics and game-flow engine for the VGA ball game.
// Moves the ball once per frame tick, bounces it, and tracks score and lives.
module ball_physics_engine #(
    parameter int COORD_W   = 12,
    parameter int SPD_W     = 4,
    parameter int SCORE_W   = 8,
    parameter int TICK_DIV  = 416667,
    parameter int FIELD_L   = 100,
    parameter int FIELD_R   = 540,
    parameter int PADDLE_Y  = 470,
    parameter int BALL_SZ   = 10,
    parameter int LIVES     = 3,
    parameter int CEIL_STEP = 10,
    parameter int CEIL_MAX  = 400
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               launch,
    input  logic [COORD_W-1:0] paddle_left,
    input  logic [COORD_W-1:0] paddle_half,
    input  logic [SPD_W-1:0]   dx_init,
    input  logic [SPD_W-1:0]   dy_init,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] ceiling,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic [1:0]         state,
    output logic               frame_tick,
    output logic               paddle_lock
);

    localparam int SW = COORD_W + 2;
    localparam int PW = COORD_W + 3;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic signed [SW-1:0] L_FL = SW'(FIELD_L);
    localparam logic signed [SW-1:0] L_FR = SW'(FIELD_R);
    localparam logic signed [SW-1:0] L_PY = SW'(PADDLE_Y);
    localparam logic signed [SW-1:0] L_BS = SW'(BALL_SZ);

    localparam logic signed [PW-1:0] P_FL  = PW'(FIELD_L);
    localparam logic signed [PW-1:0] P_FRB = PW'(FIELD_R - BALL_SZ);
    localparam logic signed [PW-1:0] P_BS  = PW'(BALL_SZ);
    localparam logic signed [PW-1:0] P_HB  = PW'(BALL_SZ / 2);

    typedef enum logic [1:0] {
        S_WAIT = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    state_t             r_state, w_state_n;
    logic [TW-1:0]      r_tick_cnt;
    logic [COORD_W-1:0] r_ball_x, w_ball_x_n;
    logic [COORD_W-1:0] r_ball_y, w_ball_y_n;
    logic [COORD_W-1:0] r_ceiling, w_ceiling_n;
    logic [SCORE_W-1:0] r_score, w_score_n;
    logic [2:0]         r_lives, w_lives_n;
    logic               r_dir_x, w_dir_x_n;
    logic               r_dir_y, w_dir_y_n;
    logic [SPD_W-1:0]   r_dx, w_dx_n;
    logic [SPD_W-1:0]   r_dy, w_dy_n;
    logic               r_pend, w_pend_n;

    logic                w_tick;
    logic signed [SW-1:0] w_x, w_y, w_dx, w_dy, w_ceil;
    logic signed [SW-1:0] w_nx, w_ny;
    logic                w_nx_dir, w_ny_dir;
    logic                w_at_pad, w_catch;
    logic signed [PW-1:0] w_nxp, w_pl, w_pr;
    logic signed [PW-1:0] w_wx, w_wxc;
    logic [COORD_W:0]    w_ceil_inc;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Candidate move for this tick; dir 1 = right / up (y shrinks going up).
    always_comb begin
        w_x      = $signed({2'b00, r_ball_x});
        w_y      = $signed({2'b00, r_ball_y});
        w_ceil   = $signed({2'b00, r_ceiling});
        w_dx     = $signed({{(SW - SPD_W){1'b0}}, r_dx});
        w_dy     = $signed({{(SW - SPD_W){1'b0}}, r_dy});
        w_nx_dir = r_dir_x;
        w_ny_dir = r_dir_y;
        w_at_pad = 1'b0;

        if (r_dir_x) begin
            w_nx = w_x + w_dx;
            if (w_nx + L_BS >= L_FR) begin
                w_nx     = L_FR - L_BS;
                w_nx_dir = 1'b0;
            end
        end else begin
            w_nx = w_x - w_dx;
            if (w_nx <= L_FL) begin
                w_nx     = L_FL;
                w_nx_dir = 1'b1;
            end
        end

        if (r_dir_y) begin
            w_ny = w_y - w_dy;
            if (w_ny - L_BS <= w_ceil) begin
                w_ny     = w_ceil + L_BS;
                w_ny_dir = 1'b0;
            end
        end else begin
            w_ny = w_y + w_dy;
            if (w_ny >= L_PY) begin
                w_ny     = L_PY;
                w_at_pad = 1'b1;
            end
        end
    end

    // Paddle span needs one more bit: left + 2*half can exceed 2^(COORD_W+1).
    always_comb begin
        w_nxp   = {w_nx[SW-1], w_nx};
        w_pl    = $signed({3'b000, paddle_left});
        w_pr    = w_pl + $signed({2'b00, paddle_half, 1'b0});
        w_catch = w_at_pad && (w_nxp >= w_pl) && (w_nxp + P_BS <= w_pr);
    end

    always_comb begin
        w_wx = $signed({3'b000, paddle_left})
             + $signed({3'b000, paddle_half}) - P_HB;
        if (w_wx < P_FL) begin
            w_wxc = P_FL;
        end else if (w_wx > P_FRB) begin
            w_wxc = P_FRB;
        end else begin
            w_wxc = w_wx;
        end
    end

    assign w_ceil_inc = {1'b0, r_ceiling} + (COORD_W + 1)'(CEIL_STEP);

    always_comb begin
        w_state_n   = r_state;
        w_ball_x_n  = r_ball_x;
        w_ball_y_n  = r_ball_y;
        w_ceiling_n = r_ceiling;
        w_score_n   = r_score;
        w_lives_n   = r_lives;
        w_dir_x_n   = r_dir_x;
        w_dir_y_n   = r_dir_y;
        w_dx_n      = r_dx;
        w_dy_n      = r_dy;
        w_pend_n    = r_pend;

        if (w_tick || r_state != S_WAIT) begin
            w_pend_n = 1'b0;
        end else if (launch) begin
            w_pend_n = 1'b1;
        end

        if (r_state == S_BAD) begin
            w_state_n = S_WAIT;
        end else if (w_tick) begin
            unique case (r_state)
                S_WAIT: begin
                    w_ball_x_n = COORD_W'(w_wxc);
                    w_ball_y_n = COORD_W'(PADDLE_Y);
                    if (r_pend || launch) begin
                        w_dx_n    = (dx_init == '0) ? SPD_W'(1) : dx_init;
                        w_dy_n    = (dy_init == '0) ? SPD_W'(1) : dy_init;
                        w_dir_x_n = 1'b1;
                        w_dir_y_n = 1'b1;
                        w_state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    w_ball_x_n = COORD_W'(w_nx);
                    w_ball_y_n = COORD_W'(w_ny);
                    w_dir_x_n  = w_nx_dir;
                    w_dir_y_n  = w_ny_dir;
                    if (w_catch) begin
                        w_dir_y_n = 1'b1;
                        if (!(&r_score)) begin
                            w_score_n = r_score + SCORE_W'(1);
                        end
                        if (w_ceil_inc > (COORD_W + 1)'(CEIL_MAX)) begin
                            w_ceiling_n = COORD_W'(CEIL_MAX);
                        end else begin
                            w_ceiling_n = w_ceil_inc[COORD_W-1:0];
                        end
                    end else if (w_at_pad) begin
                        w_lives_n = r_lives - 3'd1;
                        w_state_n = (r_lives == 3'd1) ? S_OVER : S_WAIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state   <= S_WAIT;
            r_ball_x  <= COORD_W'(FIELD_L);
            r_ball_y  <= COORD_W'(PADDLE_Y);
            r_ceiling <= '0;
            r_score   <= '0;
            r_lives   <= 3'(LIVES);
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_dx      <= SPD_W'(1);
            r_dy      <= SPD_W'(1);
            r_pend    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ball_x  <= w_ball_x_n;
            r_ball_y  <= w_ball_y_n;
            r_ceiling <= w_ceiling_n;
            r_score   <= w_score_n;
            r_lives   <= w_lives_n;
            r_dir_x   <= w_dir_x_n;
            r_dir_y   <= w_dir_y_n;
            r_dx      <= w_dx_n;
            r_dy      <= w_dy_n;
            r_pend    <= w_pend_n;
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign ceiling     = r_ceiling;
    assign score       = r_score;
    assign lives       = r_lives;
    assign state       = r_state;
    assign frame_tick  = w_tick;
    assign paddle_lock = (r_state == S_OVER);

endmodule

// File: tb/tb_ball_physics_engine.sv
// Directed bench for ball_physics_engine with a 4-cycle frame tick.
// Expected positions are hand-derived trajectories from the serve point.
module tb_ball_physics_engine;

    localparam int TD = 4;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        launch = 1'b0;
    logic [11:0] paddle_left = 12'd300;
    logic [11:0] paddle_half = 12'd30;
    logic [3:0]  dx_init = 4'd2;
    logic [3:0]  dy_init = 4'd3;
    logic [11:0] ball_x, ball_y, ceiling;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic [1:0]  state;
    logic        frame_tick, paddle_lock;

    int checks = 0;
    int failures = 0;
    int n;

    ball_physics_engine #(.TICK_DIV(TD)) dut (
        .clk_in(clk_in), .reset(reset), .launch(launch),
        .paddle_left(paddle_left), .paddle_half(paddle_half),
        .dx_init(dx_init), .dy_init(dy_init),
        .ball_x(ball_x), .ball_y(ball_y), .ceiling(ceiling),
        .score(score), .lives(lives), .state(state),
        .frame_tick(frame_tick), .paddle_lock(paddle_lock)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic next_tick();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * TD; i++) begin
            @(negedge clk_in);
            if (frame_tick === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        check("tick_seen", {31'b0, hit}, 32'd1);
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_ticks(input int cnt);
        for (int i = 0; i < cnt; i++) next_tick();
    endtask

    task automatic run_until_exit(input int maxt, output int cnt);
        cnt = 0;
        while (state == 2'b01 && cnt < maxt) begin
            next_tick();
            cnt++;
        end
    endtask

    task automatic tick_pattern(input string tag, input int ncyc,
                                input logic [15:0] exp);
        logic [15:0] p;
        p = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk_in);
            p[k] = frame_tick;
        end
        check(tag, {16'b0, p}, {16'b0, exp});
        @(posedge clk_in);
        #1;
    endtask

    task automatic pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, {20'b0, ball_x}, ex);
        check({tag, "_y"}, {20'b0, ball_y}, ey);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_state"}, {30'b0, state}, 0);
        check({tag, "_lives"}, {29'b0, lives}, 3);
        check({tag, "_score"}, {24'b0, score}, 0);
        check({tag, "_ceil"}, {20'b0, ceiling}, 0);
        check({tag, "_lock"}, {31'b0, paddle_lock}, 0);
        pos(tag, 100, 470);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        reset_vals("rst");
        check("rst_ft", {31'b0, frame_tick}, 0);
        reset = 1'b0;
        tick_pattern("ft_pattern", 12, 16'h0888);

        next_tick();
        pos("wait_c", 325, 470);
        paddle_left = 12'd50;
        next_tick();
        check("wait_clamp_l", {20'b0, ball_x}, 100);
        paddle_left = 12'd600;
        next_tick();
        check("wait_clamp_r", {20'b0, ball_x}, 530);
        paddle_left = 12'd300;
        next_tick();

        launch = 1'b1;
        @(posedge clk_in);
        #1;
        launch = 1'b0;
        check("pend_no_move", {30'b0, state}, 0);
        next_tick();
        check("launch_state", {30'b0, state}, 1);
        pos("serve", 325, 470);
        next_tick();
        pos("k1", 327, 467);
        run_ticks(101);
        pos("k102", 529, 164);
        next_tick();
        pos("wall_r", 530, 161);
        next_tick();
        pos("wall_r_back", 528, 158);
        run_ticks(49);
        pos("k153", 430, 11);
        next_tick();
        pos("ceil_hit", 428, 10);
        next_tick();
        pos("ceil_back", 426, 13);
        run_ticks(152);
        pos("k307", 122, 469);
        paddle_left = 12'd110;
        next_tick();
        pos("catch", 120, 470);
        check("catch_score", {24'b0, score}, 1);
        check("catch_ceil", {20'b0, ceiling}, 10);
        check("catch_state", {30'b0, state}, 1);
        next_tick();
        pos("rise", 118, 467);

        paddle_left = 12'd0;
        paddle_half = 12'd0;
        run_until_exit(400, n);
        check("miss1_ticks", n, 299);
        pos("miss1", 380, 470);
        check("miss1_lives", {29'b0, lives}, 2);
        check("miss1_state", {30'b0, state}, 0);
        check("miss1_score", {24'b0, score}, 1);
        check("miss1_ceil", {20'b0, ceiling}, 10);

        paddle_left = 12'd300;
        paddle_half = 12'd30;
        dx_init = 4'd0;
        dy_init = 4'd0;
        launch = 1'b1;
        next_tick();
        launch = 1'b0;
        check("s2_state", {30'b0, state}, 1);
        paddle_left = 12'd0;
        paddle_half = 12'd0;
        next_tick();
        pos("s2_k1", 326, 469);
        next_tick();
        pos("s2_k2", 327, 468);
        run_until_exit(1000, n);
        check("miss2_ticks", n, 898);
        check("miss2_x", {20'b0, ball_x}, 365);
        check("miss2_lives", {29'b0, lives}, 1);
        check("miss2_state", {30'b0, state}, 0);

        paddle_left = 12'd300;
        paddle_half = 12'd30;
        dx_init = 4'd15;
        dy_init = 4'd15;
        launch = 1'b1;
        next_tick();
        launch = 1'b0;
        check("s3_state", {30'b0, state}, 1);
        paddle_left = 12'd0;
        paddle_half = 12'd0;
        run_until_exit(100, n);
        check("miss3_ticks", n, 60);
        check("over_state", {30'b0, state}, 2);
        check("over_lock", {31'b0, paddle_lock}, 1);
        check("over_lives", {29'b0, lives}, 0);
        pos("over", 355, 470);

        launch = 1'b1;
        run_ticks(3);
        check("over_hold", {30'b0, state}, 2);
        pos("over_frozen", 355, 470);

        @(posedge clk_in);
        #1;
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        reset_vals("rst_over");
        reset = 1'b0;
        launch = 1'b0;
        tick_pattern("ft_after_over", 4, 16'h0008);

        paddle_left = 12'd300;
        paddle_half = 12'd30;
        dx_init = 4'd2;
        dy_init = 4'd3;
        launch = 1'b1;
        next_tick();
        launch = 1'b0;
        check("r2_state", {30'b0, state}, 1);
        next_tick();
        pos("r2_k1", 327, 467);
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        reset_vals("rst_run");
        reset = 1'b0;
        tick_pattern("ft_after_run", 4, 16'h0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
